// File: rtl/pipeline_fetch_if.sv
// Instruction-memory request/grant/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface pipeline_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/pipeline_fetch.sv
// RV32I instruction-fetch stage: fetch PC, imem request issue, 2-entry prefetch queue.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the outputs when the queue is empty.
module pipeline_fetch #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_stallF,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  pipeline_fetch_if.master imem,
  output logic [XLEN-1:0]  o_instrF,
  output logic [XLEN-1:0]  o_PCF,
  output logic [XLEN-1:0]  o_PCPlus4F,
  output logic             o_validF
);

  localparam int unsigned     DEPTH   = 2;
  localparam int unsigned     PTR_W   = 1;
  localparam int unsigned     CNT_W   = 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Architectural state
  logic [XLEN-1:0]  pc_q,       pc_d;
  logic [XLEN-1:0]  last_pc_q,  last_pc_d;
  logic [XLEN-1:0]  iq_instr_q [DEPTH];
  logic [XLEN-1:0]  iq_instr_d [DEPTH];
  logic [XLEN-1:0]  iq_pc_q    [DEPTH];
  logic [XLEN-1:0]  iq_pc_d    [DEPTH];
  logic [PTR_W-1:0] iq_head_q,  iq_head_d;
  logic [CNT_W-1:0] iq_cnt_q,   iq_cnt_d;
  logic [XLEN-1:0]  ifq_pc_q   [DEPTH];
  logic [XLEN-1:0]  ifq_pc_d   [DEPTH];
  logic [PTR_W-1:0] ifq_head_q, ifq_head_d;
  logic [CNT_W-1:0] out_q,      out_d;
  logic [CNT_W-1:0] drop_q,     drop_d;

  // Per-cycle decode
  logic             iq_empty_c;
  logic [PTR_W-1:0] iq_tail_c;
  logic [PTR_W-1:0] ifq_tail_c;
  logic [XLEN-1:0]  rsp_pc_c;
  logic             accept_c;
  logic             discard_c;
  logic             bypass_c;
  logic             pop_c;
  logic             push_c;
  logic [CNT_W-1:0] occ_c;
  logic             req_c;
  logic             grant_c;
  logic [XLEN-1:0]  instr_c;
  logic [XLEN-1:0]  pcf_c;
  logic             valid_c;

  // Handshake decode, credit check and output selection
  always_comb begin
    iq_empty_c = (iq_cnt_q == '0);
    iq_tail_c  = iq_head_q ^ iq_cnt_q[0];
    ifq_tail_c = ifq_head_q ^ out_q[0];
    rsp_pc_c   = ifq_pc_q[ifq_head_q];
    // A response with nothing outstanding and nothing to drop belongs to no request.
    accept_c   = imem.rvalid & (drop_q == '0) & (out_q != '0);
    discard_c  = imem.rvalid & (drop_q != '0);
`ifdef FETCH_BYPASS_EN
    bypass_c   = accept_c & iq_empty_c & ~i_stallF & ~i_redirect;
`else
    bypass_c   = 1'b0;
`endif
    pop_c      = ~iq_empty_c & ~i_stallF & ~i_redirect;
    push_c     = accept_c & ~bypass_c & ~i_redirect;
    // Credit counts the slot freed by this cycle's pop so 1-cycle memory sustains 1 IPC.
    occ_c      = iq_cnt_q - CNT_W'(pop_c);
    req_c      = ~i_redirect & (drop_q == '0)
               & (({1'b0, occ_c} + {1'b0, out_q}) < 3'd2);
    grant_c    = req_c & imem.gnt;

    valid_c = ~iq_empty_c | bypass_c;
    if (bypass_c) begin
      instr_c = imem.rdata;
      pcf_c   = rsp_pc_c;
    end else if (!iq_empty_c) begin
      instr_c = iq_instr_q[iq_head_q];
      pcf_c   = iq_pc_q[iq_head_q];
    end else begin
      instr_c = NOP_INSTR;
      pcf_c   = last_pc_q;
    end
  end

  // Next-state: redirect overrides grant, response push and pop
  always_comb begin
    pc_d       = pc_q;
    last_pc_d  = pcf_c;
    iq_instr_d = iq_instr_q;
    iq_pc_d    = iq_pc_q;
    iq_head_d  = iq_head_q;
    iq_cnt_d   = iq_cnt_q;
    ifq_pc_d   = ifq_pc_q;
    ifq_head_d = ifq_head_q;
    out_d      = out_q;
    drop_d     = drop_q;

    if (i_redirect) begin
      pc_d     = i_redirect_pc;
      iq_cnt_d = '0;
      out_d    = '0;
      // Every response still owed is stale; one arriving now is consumed this cycle.
      drop_d   = drop_q + out_q - CNT_W'(accept_c | discard_c);
    end else begin
      if (grant_c) begin
        ifq_pc_d[ifq_tail_c] = pc_q;
        pc_d                 = pc_q + PC_STEP;
      end
      if (accept_c) begin
        ifq_head_d = ~ifq_head_q;
      end
      if (discard_c) begin
        drop_d = drop_q - CNT_W'(1);
      end
      out_d = out_q + CNT_W'(grant_c) - CNT_W'(accept_c);

      if (push_c) begin
        iq_instr_d[iq_tail_c] = imem.rdata;
        iq_pc_d[iq_tail_c]    = rsp_pc_c;
      end
      if (pop_c) begin
        iq_head_d = ~iq_head_q;
      end
      iq_cnt_d = iq_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q       <= RESET_PC;
      last_pc_q  <= RESET_PC;
      iq_head_q  <= '0;
      iq_cnt_q   <= '0;
      ifq_head_q <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        iq_instr_q[i] <= NOP_INSTR;
        iq_pc_q[i]    <= RESET_PC;
        ifq_pc_q[i]   <= RESET_PC;
      end
    end else begin
      pc_q       <= pc_d;
      last_pc_q  <= last_pc_d;
      iq_instr_q <= iq_instr_d;
      iq_pc_q    <= iq_pc_d;
      iq_head_q  <= iq_head_d;
      iq_cnt_q   <= iq_cnt_d;
      ifq_pc_q   <= ifq_pc_d;
      ifq_head_q <= ifq_head_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  assign imem.req   = req_c;
  assign imem.addr  = pc_q;
  assign o_instrF   = instr_c;
  assign o_PCF      = pcf_c;
  assign o_PCPlus4F = pcf_c + PC_STEP;
  assign o_validF   = valid_c;

endmodule

// File: tb/tb_pipeline_fetch.sv
// Self-checking bench for pipeline_fetch: in-order memory model plus a stream-level
// scoreboard (expected next PC, fetch address, stale-response accounting).
module tb_pipeline_fetch;

  localparam int unsigned XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam int          NV     = 11;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, pcf, pcp4;
  logic        validf;

  pipeline_fetch_if #(.XLEN(XLEN)) bus ();

  pipeline_fetch #(
    .XLEN      (XLEN),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_stallF      (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .imem          (bus),
    .o_instrF      (instr),
    .o_PCF         (pcf),
    .o_PCPlus4F    (pcp4),
    .o_validF      (validf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic        stall;
    logic        valid;
    logic        req;
    logic [31:0] pc;
  } vec_t;

  mreq_t       mem_q[$];
  vec_t        vec[NV];
  int          cyc, lat, gnt_pct, epoch, rsp_epoch;
  int          granted, popped, total_pops;
  int          n_tests, n_fail;
  logic [31:0] exp_pc, exp_fetch, last_pc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory returns addr^KEY in order, lat cycles after the grant.
  task automatic drive_mem();
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.rvalid = 1'b1;
      bus.rdata  = mem_q[0].addr ^ KEY;
      rsp_epoch  = mem_q[0].epoch;
      void'(mem_q.pop_front());
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      rsp_epoch  = -1;
    end
    bus.gnt = ($urandom_range(0, 99) < gnt_pct);
  endtask

  // Scoreboard for one cycle; called at the negedge with inputs stable.
  task automatic observe();
    int stale;
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    if (bus.rvalid && rsp_epoch != epoch) stale++;
    if (redirect || stale != 0) check("req_while_draining", 32'(bus.req), 32'h0);

    if (validf) begin
      check("pc", pcf, exp_pc);
      check("instr", instr, exp_pc ^ KEY);
      check("pc_plus4", pcp4, exp_pc + 32'd4);
      last_pc = exp_pc;
    end else begin
      check("bubble_instr", instr, NOP);
      check("bubble_pc", pcf, last_pc);
      check("bubble_plus4", pcp4, last_pc + 32'd4);
    end

    if (bus.req && bus.gnt) begin
      check("fetch_addr", bus.addr, exp_fetch);
      mem_q.push_back('{addr: bus.addr, due: cyc + lat, epoch: epoch});
      exp_fetch = exp_fetch + 32'd4;
      granted++;
    end
    if (validf && !stall && !redirect) begin
      exp_pc = exp_pc + 32'd4;
      popped++;
      total_pops++;
    end
    check("credit_le_2", 32'(granted - popped <= 2), 32'h1);

    if (redirect) begin
      epoch++;
      exp_pc    = redirect_pc;
      exp_fetch = redirect_pc;
      granted   = 0;
      popped    = 0;
    end
  endtask

  task automatic finish_cycle();
    observe();
    @(posedge clk);
    cyc++;
    #1;
    drive_mem();
  endtask

  task automatic step();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic do_reset(input int l, input int gp);
    redirect    = 1'b0;
    stall       = 1'b0;
    redirect_pc = '0;
    bus.rvalid  = 1'b0;
    bus.gnt     = 1'b0;
    bus.rdata   = '0;
    rstn        = 1'b0;
    #1;
    check("rst_valid", 32'(validf), 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pcf, RST_PC);
    check("rst_plus4", pcp4, RST_PC + 32'd4);
    check("rst_req", 32'(bus.req), 32'h1);
    check("rst_addr", bus.addr, RST_PC);
    mem_q.delete();
    rsp_epoch = -1;
    epoch++;
    lat       = l;
    gnt_pct   = gp;
    exp_pc    = RST_PC;
    exp_fetch = RST_PC;
    last_pc   = RST_PC;
    granted   = 0;
    popped    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    cyc = 0;
    #1;
    drive_mem();
  endtask

  task automatic wait_valid(input string name, input logic [31:0] want_pc);
    int found;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (validf) begin
        found = 1;
        check({name, "_pc"}, pcf, want_pc);
        check({name, "_plus4"}, pcp4, want_pc + 32'd4);
      end
      finish_cycle();
    end
    check({name, "_seen"}, 32'(found), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; epoch = 0; cyc = 0; total_pops = 0;

    // 1-cycle memory, always granted: cycle-exact stream with a 3-cycle stall at 0x108
    vec[0]  = '{1'b0, 1'b0, 1'b1, 32'h100};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 32'h100};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 32'h100};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 32'h104};
    vec[4]  = '{1'b1, 1'b1, 1'b0, 32'h108};
    vec[5]  = '{1'b1, 1'b1, 1'b0, 32'h108};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 32'h108};
    vec[7]  = '{1'b0, 1'b1, 1'b1, 32'h108};
    vec[8]  = '{1'b0, 1'b1, 1'b1, 32'h10C};
    vec[9]  = '{1'b0, 1'b1, 1'b1, 32'h110};
    vec[10] = '{1'b0, 1'b1, 1'b1, 32'h114};

    do_reset(1, 100);
    for (int i = 0; i < NV; i++) begin
      stall = vec[i].stall;
      @(negedge clk);
      check("tbl_valid", 32'(validf), 32'(vec[i].valid));
      check("tbl_pc", pcf, vec[i].pc);
      check("tbl_instr", instr, vec[i].valid ? (vec[i].pc ^ KEY) : NOP);
      check("tbl_req", 32'(bus.req), 32'(vec[i].req));
      finish_cycle();
    end
    stall = 1'b0;
    repeat (3) step();

    // Redirect coinciding with a response and a pop
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    check("rrp_rvalid", 32'(bus.rvalid), 32'h1);
    check("rrp_valid", 32'(validf), 32'h1);
    finish_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("rrp_next_valid", 32'(validf), 32'h0);
    check("rrp_next_req", 32'(bus.req), 32'h1);
    check("rrp_next_addr", bus.addr, 32'h300);
    finish_cycle();
    wait_valid("rrp_first", 32'h300);
    repeat (4) step();

    // Wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    wait_valid("wrap", 32'hFFFF_FFFC);
    repeat (4) step();

    // Redirect with two requests outstanding on 3-cycle memory
    do_reset(3, 100);
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("drain_req", 32'(bus.req), 32'h0);
      check("drain_rvalid", 32'(bus.rvalid), 32'h1);
      finish_cycle();
    end
    @(negedge clk);
    check("drain_done_req", 32'(bus.req), 32'h1);
    check("drain_done_addr", bus.addr, 32'h200);
    finish_cycle();
    wait_valid("drain_first", 32'h200);

    // Random stall/redirect/grant on 3-cycle memory with a reset mid-stream
    do_reset(3, 60);
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 700; c++) begin
        stall       = ($urandom_range(0, 3) == 0);
        redirect    = ($urandom_range(0, 29) == 0);
        redirect_pc = 32'($urandom_range(0, 1023)) << 2;
        step();
      end
      if (phase == 0) do_reset(3, 60);
    end
    stall = 1'b0; redirect = 1'b0;
    repeat (10) step();
    check("progress", 32'(total_pops > 200), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
